// File: rtl/wb_pic8_if.sv
// Wishbone I/O slave bundle for the 8-line interrupt controller (ports 0x20/0x21).
interface wb_pic8_if;
   logic        wb_adr_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic [1:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_ack_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/wb_pic8.sv
// 8-line interrupt controller with a subset of 8259A behaviour: edge-triggered
// IRR, mask register, in-service register for nesting, EOI commands and a
// vector base. Bit 0 is the highest priority line.
module wb_pic8 #(
   parameter logic [7:0] VEC_BASE = 8'h08
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   wb_pic8_if.slave   wb,
   input  logic [7:0] irq_i,
   input  logic       inta_i,
   output logic       intr_o,
   output logic [2:0] iid_o,
   output logic [7:0] vec_o
);

   typedef enum logic {S_IDLE, S_ACK} state_t;

   state_t      state_q, state_d;
   logic [7:0]  irr_q,  irr_d;
   logic [7:0]  isr_q,  isr_d;
   logic [7:0]  imr_q,  imr_d;
   logic [7:0]  base_q, base_d;
   logic [7:0]  irq_q,  irq_d;
   logic        rsel_q, rsel_d;    // 0: low read byte is IRR, 1: ISR
   logic        icw_q,  icw_d;     // next 0x21 write loads base instead of IMR
   logic        inta_q, inta_d;
   logic        intr_q, intr_d;
   logic        ack_q,  ack_d;
   logic [2:0]  iid_q,  iid_d;
   logic [15:0] dat_q,  dat_d;

   logic [7:0] pend;
   logic [7:0] irq_rise;
   logic [2:0] hp;
   logic [2:0] hs;
   logic       inta_rise;
   logic       access;
   logic       wr_lo;
   logic       wr_hi;
   logic [7:0] cmd;
   logic [7:0] hi_byte;

   // Index of the lowest set bit, i.e. the highest-priority line; 0 when empty.
   function automatic logic [2:0] lowest_idx(input logic [7:0] v);
      lowest_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) lowest_idx = 3'(i);
      end
   endfunction

   // Decode of priority, edges and bus strobes shared by the next-state logic.
   always_comb begin
      pend      = irr_q & ~imr_q;
      hp        = lowest_idx(pend);
      hs        = lowest_idx(isr_q);
      irq_rise  = irq_i & ~irq_q;
      inta_rise = inta_i & ~inta_q;
      access    = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
      wr_lo     = access & wb.wb_we_i & ~wb.wb_adr_i & wb.wb_sel_i[0];
      wr_hi     = access & wb.wb_we_i & ~wb.wb_adr_i & wb.wb_sel_i[1];
      cmd       = wb.wb_dat_i[7:0];
      hi_byte   = wb.wb_dat_i[15:8];
   end

   // Next state: bus writes first, then acknowledge sets and new IRQ edges so
   // that sets win over clears landing in the same clock.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d = state_q;
      irr_d   = irr_q;
      isr_d   = isr_q;
      imr_d   = imr_q;
      base_d  = base_q;
      rsel_d  = rsel_q;
      icw_d   = icw_q;
      iid_d   = iid_q;
      dat_d   = dat_q;
      intr_d  = 1'b0;
      irq_d   = irq_i;
      inta_d  = inta_i;
      ack_d   = access;

      // Read data is captured with ack, from the state before this access.
      if (access) begin
         dat_d = wb.wb_adr_i ? 16'h0000 : {imr_q, rsel_q ? isr_q : irr_q};
      end

      // Port 0x20 command byte.
      if (wr_lo) begin
         if (cmd == 8'h20) begin
            if (isr_q != 8'h00) isr_d[hs] = 1'b0;
         end else if (cmd[7:3] == 5'b01100) begin
            isr_d[cmd[2:0]] = 1'b0;
         end else if (cmd == 8'h0A) begin
            rsel_d = 1'b0;
         end else if (cmd == 8'h0B) begin
            rsel_d = 1'b1;
         end else if (cmd[4]) begin
            imr_d  = 8'h00;
            isr_d  = 8'h00;
            rsel_d = 1'b0;
            icw_d  = 1'b1;
         end
      end

      // Port 0x21: mask, or vector base right after an ICW1.
      if (wr_hi) begin
         if (icw_q) begin
            base_d = hi_byte;
            icw_d  = 1'b0;
         end else begin
            imr_d = hi_byte;
         end
      end

      // Acknowledge handshake; intr_o is held low for the whole acknowledge.
      unique case (state_q)
         S_IDLE: begin
            if (inta_rise) begin
               state_d = S_ACK;
               if (pend != 8'h00) begin
                  iid_d        = hp;
                  irr_d[hp]    = 1'b0;
                  isr_d[hp]    = 1'b1;
               end else begin
                  iid_d = 3'd7;
               end
            end else begin
               intr_d = (pend != 8'h00) && ((isr_q == 8'h00) || (hp < hs));
            end
         end
         S_ACK: begin
            if (!inta_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      irr_d = irr_d | irq_rise;
   end

   // State registers. inta history resets high so a level held across reset
   // is not mistaken for a new acknowledge.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      // NOTE: all state resets here; there is no memory array left unreset.
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         irr_q   <= 8'h00;
         isr_q   <= 8'h00;
         imr_q   <= 8'hFF;
         base_q  <= VEC_BASE;
         irq_q   <= 8'h00;
         rsel_q  <= 1'b0;
         icw_q   <= 1'b0;
         inta_q  <= 1'b1;
         intr_q  <= 1'b0;
         ack_q   <= 1'b0;
         iid_q   <= 3'd0;
         dat_q   <= 16'h0000;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         irr_q   <= irr_d;
         isr_q   <= isr_d;
         imr_q   <= imr_d;
         base_q  <= base_d;
         irq_q   <= irq_d;
         rsel_q  <= rsel_d;
         icw_q   <= icw_d;
         inta_q  <= inta_d;
         intr_q  <= intr_d;
         ack_q   <= ack_d;
         iid_q   <= iid_d;
         dat_q   <= dat_d;
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;
   assign intr_o      = intr_q;
   assign iid_o       = iid_q;
   assign vec_o       = {base_q[7:3], iid_q};

endmodule

// File: tb/tb_wb_pic8.sv
// Bench for wb_pic8: directed walk through nesting, EOI, spurious and ICW1
// cases, then random traffic, all compared against a cycle-level reference
// model built from the controller's rules.
module tb_wb_pic8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] irq = 8'h00;
   logic       inta = 1'b0;
   logic       intr;
   logic [2:0] iid;
   logic [7:0] vec;

   wb_pic8_if bus();

   always #5 clk = ~clk;

   wb_pic8 #(.VEC_BASE(8'h08)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb       (bus),
      .irq_i    (irq),
      .inta_i   (inta),
      .intr_o   (intr),
      .iid_o    (iid),
      .vec_o    (vec)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model state.
   bit [7:0]  m_irr, m_isr, m_imr, m_base, m_irqh;
   bit        m_rsel, m_flag, m_intah, m_inack, m_intr, m_ack;
   bit [2:0]  m_iid;
   bit [15:0] m_dat;

   // Highest-priority line in v, or 8 when nothing is set.
   function automatic int first_set(input bit [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 8;
   endfunction

   task automatic model_reset();
      m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_base = 8'h08; m_irqh = 0;
      m_rsel = 0; m_flag = 0; m_intah = 1; m_inack = 0; m_intr = 0;
      m_ack = 0; m_iid = 0; m_dat = 0;
   endtask

   task automatic compare_outputs();
      check("intr", {15'd0, intr}, {15'd0, m_intr});
      check("iid",  {13'd0, iid},  {13'd0, m_iid});
      check("vec",  {8'd0, vec},   {8'd0, m_base[7:3], m_iid});
      check("ack",  {15'd0, bus.wb_ack_o}, {15'd0, m_ack});
      check("dat",  bus.wb_dat_o, m_dat);
   endtask

   // One clock: predict from the inputs now applied, clock, compare at negedge.
   task automatic step();
      bit [7:0]  pend, n_irr, n_isr, n_imr, n_base, b, h;
      bit        n_rsel, n_flag, n_inack, n_intr, access, took;
      bit [2:0]  n_iid;
      bit [15:0] n_dat;
      int        hp, hs;
      pend = m_irr & ~m_imr;
      hp = first_set(pend);
      hs = first_set(m_isr);
      n_irr = m_irr; n_isr = m_isr; n_imr = m_imr; n_base = m_base;
      n_rsel = m_rsel; n_flag = m_flag; n_inack = m_inack; n_iid = m_iid; n_dat = m_dat;
      access = bus.wb_stb_i && bus.wb_cyc_i && !m_ack;
      if (access) begin
         n_dat = bus.wb_adr_i ? 16'h0 : {m_imr, m_rsel ? m_isr : m_irr};
         if (bus.wb_we_i && !bus.wb_adr_i) begin
            b = bus.wb_dat_i[7:0];
            h = bus.wb_dat_i[15:8];
            if (bus.wb_sel_i[0]) begin
               if (b == 8'h20) begin
                  if (hs < 8) n_isr[hs] = 1'b0;
               end else if (b >= 8'h60 && b <= 8'h67) n_isr[b - 8'h60] = 1'b0;
               else if (b == 8'h0A) n_rsel = 1'b0;
               else if (b == 8'h0B) n_rsel = 1'b1;
               else if ((b & 8'h10) != 0) begin
                  n_imr = 0; n_isr = 0; n_rsel = 0; n_flag = 1;
               end
            end
            if (bus.wb_sel_i[1]) begin
               if (m_flag) begin n_base = h; n_flag = 0; end
               else n_imr = h;
            end
         end
      end
      took = !m_inack && inta && !m_intah;
      n_intr = 1'b0;
      if (took) begin
         n_inack = 1'b1;
         if (hp < 8) begin
            n_iid = 3'(hp); n_irr[hp] = 1'b0; n_isr[hp] = 1'b1;
         end else n_iid = 3'd7;
      end else if (m_inack) begin
         if (!inta) n_inack = 1'b0;
      end else n_intr = (hp < hs);
      n_irr = n_irr | (irq & ~m_irqh);
      @(posedge clk);
      m_irr = n_irr; m_isr = n_isr; m_imr = n_imr; m_base = n_base;
      m_rsel = n_rsel; m_flag = n_flag; m_inack = n_inack; m_iid = n_iid;
      m_dat = n_dat; m_intr = n_intr; m_ack = access;
      m_irqh = irq; m_intah = inta;
      @(negedge clk);
      compare_outputs();
   endtask

   // Reset pulse raised mid-cycle; outputs must clear before any clock edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("rst_intr", {15'd0, intr}, 16'h0);
      compare_outputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wb_write(input bit a, input bit [1:0] s, input bit [15:0] d);
      bus.wb_adr_i = a; bus.wb_sel_i = s; bus.wb_dat_i = d;
      bus.wb_we_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
      step();
      check("wr_ack", {15'd0, bus.wb_ack_o}, 16'h1);
      bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
      step();
      check("wr_ack_pulse", {15'd0, bus.wb_ack_o}, 16'h0);
   endtask

   task automatic wb_read(input bit a, output logic [15:0] d);
      bus.wb_adr_i = a; bus.wb_sel_i = 2'b11; bus.wb_we_i = 1'b0;
      bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
      step();
      d = bus.wb_dat_o;
      bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
      step();
   endtask

   task automatic pulse_irq(input bit [7:0] m);
      irq = irq | m;
      step();
      irq = irq & ~m;
      step();
      step();
   endtask

   logic [15:0] rd;
   bit   [7:0]  lo;

   initial begin
      bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_sel_i = 0;
      bus.wb_we_i = 0; bus.wb_stb_i = 0; bus.wb_cyc_i = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      compare_outputs();
      rst = 1'b0;

      // 1: masked edge still latches IRR; unmasking raises intr two clocks later.
      wb_write(0, 2'b01, 16'h000A);
      wb_read(0, rd);
      check("c1_irr_empty", rd, 16'hFF00);
      pulse_irq(8'h01);
      check("c1_intr_masked", {15'd0, intr}, 16'h0);
      wb_read(0, rd);
      check("c1_irr_imr", rd, 16'hFF01);
      wb_write(0, 2'b10, 16'hFE00);
      check("c1_intr_unmasked", {15'd0, intr}, 16'h1);
      inta = 1'b1; step();
      check("c1_iid", {13'd0, iid}, 16'd0);
      inta = 1'b0; step(); step();
      wb_write(0, 2'b01, 16'h0020);

      // 2: two lines at once, lower index wins; IRQ 3 blocked behind IRQ 1.
      wb_write(0, 2'b10, 16'h0000);
      pulse_irq(8'h0A);
      inta = 1'b1; step();
      check("c2_iid", {13'd0, iid}, 16'd1);
      check("c2_vec", {8'd0, vec}, 16'h0009);
      wb_write(0, 2'b01, 16'h000B);
      wb_read(0, rd);
      check("c2_isr", rd, 16'h0002);
      inta = 1'b0; step(); step();
      check("c2_intr_blocked", {15'd0, intr}, 16'h0);

      // 3: non-specific EOI releases IRQ 3.
      wb_write(0, 2'b01, 16'h0020);
      check("c3_intr", {15'd0, intr}, 16'h1);
      inta = 1'b1; step();
      check("c3_iid", {13'd0, iid}, 16'd3);
      inta = 1'b0; step();
      wb_read(0, rd);
      check("c3_isr", rd, 16'h0008);

      // 4: IRQ 0 nests over IRQ 3, specific EOI clears only it.
      pulse_irq(8'h01);
      check("c4_intr", {15'd0, intr}, 16'h1);
      inta = 1'b1; step();
      check("c4_iid", {13'd0, iid}, 16'd0);
      inta = 1'b0; step();
      wb_read(0, rd);
      check("c4_isr_nested", rd, 16'h0009);
      wb_write(0, 2'b01, 16'h0060);
      wb_read(0, rd);
      check("c4_isr_eoi", rd, 16'h0008);
      wb_write(0, 2'b01, 16'h0063);

      // 5: masked between request and acknowledge gives the spurious id.
      pulse_irq(8'h20);
      check("c5_intr", {15'd0, intr}, 16'h1);
      wb_write(0, 2'b10, 16'hFF00);
      check("c5_intr_masked", {15'd0, intr}, 16'h0);
      inta = 1'b1; step();
      check("c5_iid_spurious", {13'd0, iid}, 16'd7);
      inta = 1'b0; step();
      wb_read(0, rd);
      check("c5_isr_unchanged", rd, 16'hFF00);

      // 6: ICW1 then base load; reset in the middle of an acknowledge.
      wb_write(0, 2'b01, 16'h0011);
      wb_write(0, 2'b10, 16'h7000);
      pulse_irq(8'h04);
      inta = 1'b1; step();
      check("c6_iid", {13'd0, iid}, 16'd2);
      check("c6_vec", {8'd0, vec}, 16'h0072);
      do_reset();
      wb_read(0, rd);
      check("c6_imr_reset", rd, 16'hFF00);
      check("c6_no_reack", {13'd0, iid}, 16'd0);
      inta = 1'b0; step();

      // Random traffic; the model checks every output on every clock.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3) == 0) irq = irq ^ (8'h01 << $urandom_range(7));
         if ($urandom_range(5) == 0) inta = ~inta;
         bus.wb_stb_i = ($urandom_range(2) == 0);
         bus.wb_cyc_i = bus.wb_stb_i;
         bus.wb_we_i  = $urandom_range(1);
         bus.wb_adr_i = ($urandom_range(7) == 0);
         bus.wb_sel_i = $urandom_range(1) ? 2'b01 : 2'b10;
         case ($urandom_range(7))
            0, 1:    lo = 8'h20;
            2, 3:    lo = 8'h60 | 8'($urandom_range(7));
            4:       lo = 8'h0A;
            5:       lo = 8'h0B;
            6:       lo = ($urandom_range(9) == 0) ? 8'h13 : 8'h00;
            default: lo = 8'($urandom_range(255)) & 8'hEF;
         endcase
         bus.wb_dat_i = {($urandom_range(1) ? 8'h00 : 8'($urandom_range(255))), lo};
         if ($urandom_range(249) == 0) do_reset();
         else step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
